nonogram_loader: RTL

Frame-level controller sitting directly behind the UART byte receiver. It turns the raw byte stream from the host into a validated puzzle load: board dimensions plus per-line clue lists, written into the solver's clue memory. It also sequences the load against the solver, rejects malformed frames, and pulses a single done or error indication per frame.

---
 rtl/nonogram_loader.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nonogram_loader.sv
// nonogram_loader: frame parser between the UART byte receiver and the
// solver's clue memory. Validates dimensions, counts, clues and checksum,
// streams counts/clues to memory, and pulses load_done or load_err per frame.
module nonogram_loader #(
   parameter int MAX_DIM        = 15,
   parameter int MAX_CLUES      = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   localparam int DW = $clog2(MAX_DIM + 1),
   localparam int LW = $clog2(2 * MAX_DIM),
   localparam int SW = $clog2(MAX_CLUES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          solver_busy,
   output logic          cnt_we,
   output logic          clue_we,
   output logic [LW-1:0] clue_line,
   output logic [SW-1:0] clue_slot,
   output logic [7:0]    clue_val,
   output logic [DW-1:0] rows,
   output logic [DW-1:0] cols,
   output logic          busy,
   output logic          load_done,
   output logic          load_err,
   output logic [1:0]    err_code
);

   localparam int CW = $clog2(MAX_CLUES + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [7:0]    SYNC        = 8'hA5;
   localparam logic [7:0]    MAX_DIM_B   = 8'(MAX_DIM);
   localparam logic [7:0]    MAX_CLUES_B = 8'(MAX_CLUES);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ROWS, S_COLS, S_COUNT, S_CLUE, S_CHECK} state_t;
   typedef enum logic [1:0] {ERR_TIMEOUT = 2'd0, ERR_DIM = 2'd1, ERR_CLUE = 2'd2, ERR_CSUM = 2'd3} err_t;

   state_t        state_q, state_d;
   logic [DW-1:0] rows_q, rows_d, cols_q, cols_d;
   logic [LW-1:0] line_q, line_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [CW-1:0] ncl_q, ncl_d;
   logic [7:0]    xor_q, xor_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          cnt_we_q, cnt_we_d, clue_we_q, clue_we_d;
   logic [LW-1:0] clue_line_q, clue_line_d;
   logic [SW-1:0] clue_slot_q, clue_slot_d;
   logic [7:0]    clue_val_q, clue_val_d;
   logic          busy_q, busy_d, load_done_q, load_done_d, load_err_q, load_err_d;
   err_t          err_code_q, err_code_d;

   // Frame geometry helpers: index of the final line, the current line's
   // length (rows carry column-count clues and vice versa), last clue of line.
   logic [LW-1:0] last_line;
   logic [7:0]    line_len;
   logic          last_clue;

   assign last_line = LW'(rows_q) + LW'(cols_q) - LW'(1);
   assign line_len  = (line_q < LW'(rows_q)) ? 8'(cols_q) : 8'(rows_q);
   assign last_clue = (CW'(slot_q) + CW'(1)) == ncl_q;

   // Next-state, validation, timeout and registered-output computation.
   always_comb begin
      logic err_v;
      err_t code_v;
      logic adv_v;
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      line_d      = line_q;
      slot_d      = slot_q;
      ncl_d       = ncl_q;
      xor_d       = xor_q;
      tmo_d       = tmo_q;
      cnt_we_d    = 1'b0;
      clue_we_d   = 1'b0;
      clue_line_d = clue_line_q;
      clue_slot_d = clue_slot_q;
      clue_val_d  = clue_val_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      err_code_d  = err_code_q;
      err_v       = 1'b0;
      code_v      = ERR_TIMEOUT;
      adv_v       = 1'b0;

      // Idle-gap watchdog; an arriving byte always beats the limit.
      if (state_q == S_IDLE || rx_valid) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         tmo_d  = '0;
         err_v  = 1'b1;
         code_v = ERR_TIMEOUT;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      if (rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (rx_data == SYNC && !solver_busy) begin
                  state_d = S_ROWS;
                  xor_d   = '0;
               end
            end
            S_ROWS: begin
               xor_d = xor_q ^ rx_data;
               if (rx_data == 8'd0 || rx_data > MAX_DIM_B) begin
                  err_v  = 1'b1;
                  code_v = ERR_DIM;
               end else begin
                  rows_d  = rx_data[DW-1:0];
                  state_d = S_COLS;
               end
            end
            S_COLS: begin
               xor_d = xor_q ^ rx_data;
               if (rx_data == 8'd0 || rx_data > MAX_DIM_B) begin
                  err_v  = 1'b1;
                  code_v = ERR_DIM;
               end else begin
                  cols_d  = rx_data[DW-1:0];
                  line_d  = '0;
                  state_d = S_COUNT;
               end
            end
            S_COUNT: begin
               xor_d = xor_q ^ rx_data;
               if (rx_data > MAX_CLUES_B) begin
                  err_v  = 1'b1;
                  code_v = ERR_CLUE;
               end else begin
                  cnt_we_d    = 1'b1;
                  clue_line_d = line_q;
                  clue_slot_d = '0;
                  clue_val_d  = rx_data;
                  if (rx_data == 8'd0) begin
                     adv_v = 1'b1;
                  end else begin
                     ncl_d   = rx_data[CW-1:0];
                     slot_d  = '0;
                     state_d = S_CLUE;
                  end
               end
            end
            S_CLUE: begin
               xor_d = xor_q ^ rx_data;
               if (rx_data == 8'd0 || rx_data > line_len) begin
                  err_v  = 1'b1;
                  code_v = ERR_CLUE;
               end else begin
                  clue_we_d   = 1'b1;
                  clue_line_d = line_q;
                  clue_slot_d = slot_q;
                  clue_val_d  = rx_data;
                  if (last_clue) adv_v = 1'b1;
                  else           slot_d = slot_q + SW'(1);
               end
            end
            S_CHECK: begin
               if (rx_data == xor_q) begin
                  load_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  err_v  = 1'b1;
                  code_v = ERR_CSUM;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (adv_v) begin
         if (line_q == last_line) begin
            state_d = S_CHECK;
         end else begin
            line_d  = line_q + LW'(1);
            state_d = S_COUNT;
         end
      end

      if (err_v) begin
         load_err_d = 1'b1;
         err_code_d = code_v;
         state_d    = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         line_q      <= '0;
         slot_q      <= '0;
         ncl_q       <= '0;
         xor_q       <= '0;
         tmo_q       <= '0;
         cnt_we_q    <= 1'b0;
         clue_we_q   <= 1'b0;
         clue_line_q <= '0;
         clue_slot_q <= '0;
         clue_val_q  <= '0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         err_code_q  <= ERR_TIMEOUT;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         line_q      <= line_d;
         slot_q      <= slot_d;
         ncl_q       <= ncl_d;
         xor_q       <= xor_d;
         tmo_q       <= tmo_d;
         cnt_we_q    <= cnt_we_d;
         clue_we_q   <= clue_we_d;
         clue_line_q <= clue_line_d;
         clue_slot_q <= clue_slot_d;
         clue_val_q  <= clue_val_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign cnt_we    = cnt_we_q;
   assign clue_we   = clue_we_q;
   assign clue_line = clue_line_q;
   assign clue_slot = clue_slot_q;
   assign clue_val  = clue_val_q;
   assign rows      = rows_q;
   assign cols      = cols_q;
   assign busy      = busy_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
   assign err_code  = err_code_q;

endmodule
